// File: rtl/uart_transceiver.sv
// uart_transceiver: runtime-configurable UART TX/RX with 16x oversampling; define UART_BREAK_DETECT_EN for break detection
module uart_transceiver #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  localparam int CW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [CW-1:0]         cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic                  rx_uart,
  output logic                  tx_uart,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_overrun,
  output logic                  rx_break
);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_st_t;
  function automatic logic [CW-1:0] eff_bits(input logic [CW-1:0] b);
    return (b < CW'(5) || b > CW'(DATA_WIDTH)) ? CW'(DATA_WIDTH) : b;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] bit_mask(input logic [CW-1:0] n);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = i < int'(n);
    return m;
  endfunction
  // a new divisor is only picked up on wrap so the current tick period is never cut short
  logic [DIV_WIDTH-1:0] cnt, div_q;
  logic tick;
  assign tick = cnt == div_q;
  always_ff @(posedge clk)
    if (reset || tick) begin
      cnt <= '0;
      div_q <= baud_div;
    end else cnt <= cnt + 1'b1;
  tx_st_t ts, ts_n;
  logic [3:0] t_sub;
  logic [CW-1:0] t_idx, t_n;
  logic [1:0] t_par;
  logic t_s2, t_pb, t_end, t_bit;
  logic [DATA_WIDTH-1:0] t_dat, t_masked;
  assign t_end = tick && t_sub == 4'hf;
  assign t_masked = tx_data & bit_mask(eff_bits(cfg_data_bits));
  always_ff @(posedge clk) ts <= reset ? T_IDLE : ts_n;
  always_comb begin
    ts_n = ts;
    case (ts)
      T_IDLE:  ts_n = tx_valid ? T_START : T_IDLE;
      T_START: ts_n = t_end ? T_DATA : T_START;
      T_DATA:  ts_n = (!t_end || t_idx != t_n - 1'b1) ? T_DATA : ^t_par ? T_PAR : T_STOP1;
      T_PAR:   ts_n = t_end ? T_STOP1 : T_PAR;
      T_STOP1: ts_n = !t_end ? T_STOP1 : t_s2 ? T_STOP2 : T_IDLE;
      T_STOP2: ts_n = t_end ? T_IDLE : T_STOP2;
      default: ts_n = T_IDLE;
    endcase
  end
  always_comb begin
    tx_ready = ts == T_IDLE;
    t_bit = ts == T_START ? 1'b0 : ts == T_DATA ? t_dat[0] : ts == T_PAR ? t_pb : 1'b1;
  end
  // the line only moves on ticks, so each bit starts one tick after its state is entered
  always_ff @(posedge clk)
    if (reset) begin
      tx_uart <= 1'b1;
      t_sub <= '0;
      t_idx <= '0;
      t_n <= '0;
      t_par <= '0;
      t_s2 <= 1'b0;
      t_pb <= 1'b0;
      t_dat <= '0;
    end else begin
      tx_uart <= tick ? t_bit : tx_uart;
      if (ts == T_IDLE) begin
        t_sub <= '0;
        t_idx <= '0;
        if (tx_valid) begin
          t_n <= eff_bits(cfg_data_bits);
          t_par <= cfg_parity;
          t_s2 <= cfg_stop2;
          t_dat <= t_masked;
          t_pb <= ^t_masked ^ cfg_parity[1];
        end
      end else if (tick) begin
        t_sub <= t_sub + 1'b1;
        if (t_end && ts == T_DATA) begin
          t_idx <= t_idx + 1'b1;
          t_dat <= t_dat >> 1;
        end
      end
    end
  rx_st_t rs, rs_n;
  logic r_s1, r_s, r_samp, r_end, r_pb, r_brk, stop_hit, deliver, load, r_perr;
  logic [3:0] r_sub;
  logic [CW-1:0] r_idx, r_n;
  logic [1:0] r_par;
  logic [DATA_WIDTH-1:0] r_sh;
  assign r_samp = tick && r_sub == 4'd8;
  assign r_end = tick && r_sub == 4'hf;
  assign stop_hit = rs == R_STOP && r_samp;
  assign deliver = stop_hit && !r_brk;
  assign load = deliver && (!rx_valid || rx_ready);
  assign r_perr = ^r_par && ((^r_sh ^ r_par[1]) != r_pb);
`ifdef UART_BREAK_DETECT_EN
  logic r_allz;
  always_ff @(posedge clk)
    if (reset) r_allz <= 1'b0;
    else if (rs == R_START && r_samp) r_allz <= 1'b1;
    else if ((rs == R_DATA || rs == R_PAR) && r_samp) r_allz <= r_allz & ~r_s;
  assign r_brk = r_allz & ~r_s;
`else
  assign r_brk = 1'b0;
`endif
  always_ff @(posedge clk) rs <= reset ? R_IDLE : rs_n;
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  rs_n = r_s ? R_IDLE : R_START;
      R_START: rs_n = (r_samp && r_s) ? R_IDLE : r_end ? R_DATA : R_START;
      R_DATA:  rs_n = (!r_end || r_idx != r_n - 1'b1) ? R_DATA : ^r_par ? R_PAR : R_STOP;
      R_PAR:   rs_n = r_end ? R_STOP : R_PAR;
      R_STOP:  rs_n = !r_samp ? R_STOP : r_brk ? R_BRK : R_IDLE;
      R_BRK:   rs_n = r_s ? R_IDLE : R_BRK;
      default: rs_n = R_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_s1 <= 1'b1;
      r_s <= 1'b1;
      r_sub <= '0;
      r_idx <= '0;
      r_n <= '0;
      r_par <= '0;
      r_pb <= 1'b0;
      r_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      r_s1 <= rx_uart;
      r_s <= r_s1;
      r_sub <= (rs == R_IDLE || rs == R_BRK) ? '0 : tick ? r_sub + 1'b1 : r_sub;
      if (rs == R_START && r_samp) begin
        r_n <= eff_bits(cfg_data_bits);
        r_par <= cfg_parity;
        r_sh <= '0;
        r_idx <= '0;
      end
      if (rs == R_DATA && r_samp) r_sh <= r_sh | (DATA_WIDTH'(r_s) << r_idx);
      if (rs == R_DATA && r_end) r_idx <= r_idx + 1'b1;
      if (rs == R_PAR && r_samp) r_pb <= r_s;
      rx_valid <= load | (rx_valid & ~rx_ready);
      if (load) begin
        rx_data <= r_sh;
        rx_parity_err <= r_perr;
        rx_frame_err <= ~r_s;
      end
      rx_overrun <= deliver && !load;
      rx_break <= stop_hit && r_brk;
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed scoreboard bench for uart_transceiver
module tb_uart_transceiver;
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] baud_div = '0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic cfg_stop2 = 1'b0;
  logic rx_uart, tx_uart, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b1;
  logic rx_parity_err, rx_frame_err, rx_overrun, rx_break;
  logic [7:0] tx_data = '0, rx_data;
  logic loop = 1'b1, rx_drv = 1'b1;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, ovr_cnt = 0, brk_cnt = 0;
  assign rx_uart = loop ? tx_uart : rx_drv;
  always #5 clk = ~clk;
  uart_transceiver #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx_uart(rx_uart), .tx_uart(tx_uart),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_break(rx_break));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // monitor: every RX handshake is checked against the oldest expected character
  always @(negedge clk)
    if (!reset) begin
      if (rx_overrun) ovr_cnt++;
      if (rx_break) brk_cnt++;
      if (rx_valid && rx_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected no character", rx_data);
        end else begin
          e = q.pop_front();
          check("rx_data", rx_data, e.d);
          check("rx_parity_err", rx_parity_err, e.pe);
          check("rx_frame_err", rx_frame_err, e.fe);
        end
      end
    end
  task automatic tx_send(input logic [7:0] d, input logic [1:0] par_at, input logic [1:0] par_after);
    int n = 0;
    while (!tx_ready && n < 5000) begin
      cyc(1);
      n++;
    end
    if (!tx_ready) fail("tx_ready_wait");
    tx_data = d;
    cfg_parity = par_at;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    cfg_parity = par_after;
  endtask
  task automatic drive_frame(input logic [7:0] d, input int n, input logic [1:0] par, input logic stop);
    int bp = 16 * (int'(baud_div) + 1);
    logic p = 1'b0;
    rx_drv = 1'b0;
    cyc(bp);
    for (int i = 0; i < n; i++) begin
      rx_drv = d[i];
      p ^= d[i];
      cyc(bp);
    end
    if (par == 2'b01 || par == 2'b10) begin
      rx_drv = p ^ par[1];
      cyc(bp);
    end
    rx_drv = stop;
    cyc(bp);
    rx_drv = 1'b1;
    cyc(bp);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      cyc(1);
      n++;
    end
    if (q.size() != 0) begin
      fail("rx_drain");
      q.delete();
    end
    cyc(4);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] fr, bad, mid;
    int lowcnt, b0, o0;
    cyc(3);
    check("reset_tx_uart", tx_uart, 1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_perr", rx_parity_err, 0);
    check("reset_rx_ferr", rx_frame_err, 0);
    reset = 1'b0;
    cyc(2);
    // 8N1 at one tick per cycle: exact bit timing of 0xA5
    fr = {1'b1, 8'hA5, 1'b0};
    bad = '0;
    mid = '0;
    lowcnt = 0;
    q.push_back(exp_t'{8'hA5, 1'b0, 1'b0});
    tx_send(8'hA5, 2'b00, 2'b00);
    for (int i = 0; i < 2000 && !tx_ready; i++) begin
      lowcnt++;
      if (i >= 1 && i <= 160) begin
        if (tx_uart !== fr[(i - 1) / 16]) bad[(i - 1) / 16] = 1'b1;
        if ((i - 1) % 16 == 7) mid[(i - 1) / 16] = tx_uart;
      end
      cyc(1);
    end
    for (int k = 0; k < 10; k++) check($sformatf("tx_bit%0d", k), mid[k], fr[k]);
    check("tx_bit_width", bad, 0);
    check("tx_ready_low_cycles", lowcnt, 160);
    drain();
    // 7E2 loopback, then odd RX against even TX by switching parity after TX accepts
    baud_div = 16'd3;
    cfg_data_bits = 4'd7;
    cfg_stop2 = 1'b1;
    q.push_back(exp_t'{8'h55, 1'b0, 1'b0});
    q.push_back(exp_t'{8'h2A, 1'b0, 1'b0});
    tx_send(8'h55, 2'b01, 2'b01);
    tx_send(8'h2A, 2'b01, 2'b01);
    drain();
    q.push_back(exp_t'{8'h55, 1'b1, 1'b0});
    q.push_back(exp_t'{8'h2A, 1'b1, 1'b0});
    tx_send(8'h55, 2'b01, 2'b10);
    tx_send(8'h2A, 2'b01, 2'b10);
    drain();
    cyc(200);
    cfg_parity = 2'b00;
    cfg_data_bits = 4'd8;
    cfg_stop2 = 1'b0;
    loop = 1'b0;
    cyc(10);
    // stop bit forced low
    q.push_back(exp_t'{8'h3C, 1'b0, 1'b1});
    drive_frame(8'h3C, 8, 2'b00, 1'b0);
    drain();
    // 5-tick glitch is a false start
    rx_drv = 1'b0;
    cyc(20);
    rx_drv = 1'b1;
    cyc(200);
    q.push_back(exp_t'{8'h81, 1'b0, 1'b0});
    drive_frame(8'h81, 8, 2'b00, 1'b1);
    drain();
    // overrun with the consumer stalled
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    q.push_back(exp_t'{8'h11, 1'b0, 1'b0});
    drive_frame(8'h11, 8, 2'b00, 1'b1);
    drive_frame(8'h22, 8, 2'b00, 1'b1);
    cyc(10);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data_held", rx_data, 8'h11);
    check("ovr_pulses", ovr_cnt - o0, 1);
    rx_ready = 1'b1;
    cyc(1);
    check("ovr_rx_valid_cleared", rx_valid, 0);
    drain();
    // line held low
    b0 = brk_cnt;
`ifdef UART_BREAK_DETECT_EN
    rx_drv = 1'b0;
    cyc(20 * 64);
    rx_drv = 1'b1;
    cyc(128);
    check("break_pulses", brk_cnt - b0, 1);
    check("break_rx_valid", rx_valid, 0);
`else
    q.push_back(exp_t'{8'h00, 1'b0, 1'b1});
    rx_drv = 1'b0;
    cyc(10 * 64);
    rx_drv = 1'b1;
    cyc(128);
    drain();
    check("break_pulses", brk_cnt - b0, 0);
`endif
    q.push_back(exp_t'{8'hF0, 1'b0, 1'b0});
    drive_frame(8'hF0, 8, 2'b00, 1'b1);
    drain();
    // reset in the middle of a TX frame
    loop = 1'b1;
    tx_send(8'hFF, 2'b00, 2'b00);
    cyc(50);
    check("midtx_tx_uart_low", tx_uart, 0);
    reset = 1'b1;
    cyc(1);
    check("rst_tx_uart", tx_uart, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    reset = 1'b0;
    cyc(1500);
    check("rx_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
